// File: rtl/muladd_vec_engine.sv
// ============================================================================
// Module   : muladd_vec_engine
// Purpose  : Streaming multiply-accumulate dot-product engine with a
//            one-entry saturating/wrapping result buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muladd_vec_engine #(
  parameter int OP_W    = 16,
  parameter int VEC_LEN = 8,
  parameter int ACC_W   = 40,
  parameter int OUT_W   = 32,
  parameter int SAT_EN  = 1,
  localparam int LEN_W  = $clog2(VEC_LEN + 1)
) (
  input  logic              clk_pe,
  input  logic              rst,
  input  logic              load_en_i,
  input  logic [2*OP_W-1:0] load_payload_i,
  input  logic              load_last_i,
  input  logic              mode_signed_i,
  output logic              load_ready_o,
  output logic              result_valid_o,
  input  logic              result_ready_i,
  output logic [OUT_W-1:0]  result_payload_o,
  output logic              result_sat_o,
  output logic [LEN_W-1:0]  result_len_o
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  state_t                   r_state;
  logic [LEN_W-1:0]         r_cnt;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_mode;
  logic                     r_valid;
  logic [OUT_W-1:0]         r_payload;
  logic                     r_sat;
  logic [LEN_W-1:0]         r_len;

  logic [OP_W-1:0]          w_a;
  logic [OP_W-1:0]          w_b;
  logic                     w_mode;
  logic signed [ACC_W-1:0]  w_a_ext;
  logic signed [ACC_W-1:0]  w_b_ext;
  logic signed [ACC_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]  w_sum;
  logic [LEN_W-1:0]         w_cnt_nxt;
  logic                     w_final;
  logic                     w_ready;
  logic                     w_beat;
  logic                     w_ovf;
  logic [OUT_W-1:0]         w_clip;
  logic [OUT_W-1:0]         w_conv;

  assign w_a       = load_payload_i[OP_W-1:0];
  assign w_b       = load_payload_i[2*OP_W-1:OP_W];
  // The first beat of a vector uses the live mode; later beats use the latched one.
  assign w_mode    = (r_state == S_IDLE) ? mode_signed_i : r_mode;
  assign w_a_ext   = {{(ACC_W-OP_W){w_mode & w_a[OP_W-1]}}, w_a};
  assign w_b_ext   = {{(ACC_W-OP_W){w_mode & w_b[OP_W-1]}}, w_b};
  assign w_prod    = w_a_ext * w_b_ext;
  assign w_sum     = r_acc + w_prod;
  assign w_cnt_nxt = r_cnt + LEN_W'(1);
  assign w_final   = load_last_i || (r_cnt == LEN_W'(VEC_LEN - 1));
  assign w_ready   = !r_valid || result_ready_i;
  assign w_beat    = load_en_i && w_ready;

  generate
    if (OUT_W < ACC_W) begin : g_narrow
      logic [ACC_W-OUT_W:0] w_top;
      assign w_top = w_sum[ACC_W-1:OUT_W-1];
      // Signed fits when the discarded bits replicate the new sign bit.
      assign w_ovf = w_mode ? !((&w_top) || !(|w_top)) : (|w_top[ACC_W-OUT_W:1]);
    end else begin : g_full
      assign w_ovf = 1'b0;
    end
  endgenerate

  assign w_clip = !w_mode ? {OUT_W{1'b1}} :
                  (w_sum[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}});
  assign w_conv = ((SAT_EN != 0) && w_ovf) ? w_clip : w_sum[OUT_W-1:0];

  always_ff @(posedge clk_pe) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mode    <= 1'b0;
      r_valid   <= 1'b0;
      r_payload <= '0;
      r_sat     <= 1'b0;
      r_len     <= '0;
    end else begin
      if (r_valid && result_ready_i) begin
        r_valid <= 1'b0;
      end
      if (w_beat) begin
        if (r_state == S_IDLE) begin
          r_mode <= mode_signed_i;
        end
        if (w_final) begin
          r_state   <= S_IDLE;
          r_cnt     <= '0;
          r_acc     <= '0;
          r_valid   <= 1'b1;
          r_payload <= w_conv;
          r_sat     <= w_ovf;
          r_len     <= w_cnt_nxt;
        end else begin
          r_state <= S_ACCUM;
          r_cnt   <= w_cnt_nxt;
          r_acc   <= w_sum;
        end
      end
    end
  end

  assign load_ready_o     = w_ready;
  assign result_valid_o   = r_valid;
  assign result_payload_o = r_payload;
  assign result_sat_o     = r_sat;
  assign result_len_o     = r_len;

endmodule

`default_nettype wire
